// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage producer-side hazard unit.
// Tracks destination registers with an outstanding long-latency write (load miss,
// mul/div) and stalls ID on load-use, RAW against pending writes, WAW and full
// pending capacity. A completion arriving in the same cycle is bypassed.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 16,
    localparam int PW      = $clog2(MAX_PEND) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ID_valid,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_RegWrite,
    input  logic             ID_long,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd,
    input  logic             flush,
    input  logic             cmp_valid,
    input  logic [4:0]       cmp_rd,
    output logic             stall,
    output logic             issue,
    output logic [NREG-1:0]  busy_vec,
    output logic [PW-1:0]    pend_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_spurious
);

    // One-hot decode of a register index into a bitmap.
    function automatic logic [NREG-1:0] onehot(input logic [4:0] idx);
        logic [NREG-1:0] v;
        v = {{(NREG-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

    logic [NREG-1:0]  busy_r;
    logic [PW-1:0]    pend_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             err_r;

    logic [NREG-1:0]  clr_vec_s;
    logic [NREG-1:0]  eff_busy_s;
    logic             clr_any_s;
    logic [PW-1:0]    pend_eff_s;
    logic             load_use_s;
    logic             raw_s;
    logic             waw_s;
    logic             full_s;
    logic             live_s;
    logic             stall_s;
    logic             issue_s;
    logic             spur_s;

    // Hazard detection with same-cycle completion bypass.
    always_comb begin
        clr_vec_s  = '0;
        eff_busy_s = '0;
        clr_any_s  = 1'b0;
        pend_eff_s = '0;
        load_use_s = 1'b0;
        raw_s      = 1'b0;
        waw_s      = 1'b0;
        full_s     = 1'b0;
        live_s     = 1'b0;
        stall_s    = 1'b0;
        issue_s    = 1'b0;
        spur_s     = 1'b0;

        if (cmp_valid) begin
            clr_vec_s = onehot(cmp_rd) & busy_r;
            spur_s    = (cmp_rd == 5'd0) | ~busy_r[cmp_rd];
        end else begin
            clr_vec_s = '0;
            spur_s    = 1'b0;
        end
        clr_any_s  = |clr_vec_s;
        eff_busy_s = busy_r & ~clr_vec_s;
        pend_eff_s = pend_r - {{(PW-1){1'b0}}, clr_any_s};

        live_s     = ID_valid & ~flush;
        load_use_s = EX_MemRead & (EX_rd != 5'd0) &
                     ((ID_use_rs1 & (ID_rs1 == EX_rd)) | (ID_use_rs2 & (ID_rs2 == EX_rd)));
        raw_s      = (ID_use_rs1 & eff_busy_s[ID_rs1]) | (ID_use_rs2 & eff_busy_s[ID_rs2]);
        waw_s      = ID_RegWrite & eff_busy_s[ID_rd];
        full_s     = ID_long & ID_RegWrite & (ID_rd != 5'd0) & (pend_eff_s == PW'(MAX_PEND));

        stall_s = live_s & (load_use_s | raw_s | waw_s | full_s);
        issue_s = live_s & ~stall_s & ID_RegWrite & ID_long & (ID_rd != 5'd0);
    end

    // Pending-write bitmap, pending count, stall counter and sticky error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_r      <= '0;
            pend_r      <= '0;
            stall_cnt_r <= '0;
            err_r       <= 1'b0;
        end else begin
            if (issue_s) begin
                busy_r <= (busy_r & ~clr_vec_s) | onehot(ID_rd);
            end else begin
                busy_r <= busy_r & ~clr_vec_s;
            end
            pend_r <= pend_r + {{(PW-1){1'b0}}, issue_s} - {{(PW-1){1'b0}}, clr_any_s};
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (spur_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign stall        = stall_s;
    assign issue        = issue_s;
    assign busy_vec     = busy_r;
    assign pend_cnt     = pend_r;
    assign stall_cnt    = stall_cnt_r;
    assign err_spurious = err_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle expectations are queued
// when stimulus is applied and compared when the DUT produces the outputs.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rstn;
    logic        ID_valid;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_use_rs1;
    logic        ID_use_rs2;
    logic [4:0]  ID_rd;
    logic        ID_RegWrite;
    logic        ID_long;
    logic        EX_MemRead;
    logic [4:0]  EX_rd;
    logic        flush;
    logic        cmp_valid;
    logic [4:0]  cmp_rd;
    logic        stall;
    logic        issue;
    logic [31:0] busy_vec;
    logic [2:0]  pend_cnt;
    logic [15:0] stall_cnt;
    logic        err_spurious;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic        stall;
        logic        issue;
        logic [31:0] busy;
        logic [2:0]  pend;
    } exp_t;

    exp_t sb_q[$];

    hazard_scoreboard dut (
        .clk(clk), .rstn(rstn), .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_rd(ID_rd),
        .ID_RegWrite(ID_RegWrite), .ID_long(ID_long), .EX_MemRead(EX_MemRead),
        .EX_rd(EX_rd), .flush(flush), .cmp_valid(cmp_valid), .cmp_rd(cmp_rd),
        .stall(stall), .issue(issue), .busy_vec(busy_vec), .pend_cnt(pend_cnt),
        .stall_cnt(stall_cnt), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ID_valid = 1'b0; ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
        ID_rd = 5'd0; ID_RegWrite = 1'b0; ID_long = 1'b0; EX_MemRead = 1'b0; EX_rd = 5'd0;
        flush = 1'b0; cmp_valid = 1'b0; cmp_rd = 5'd0;
    endtask

    task automatic id_op(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rw, input logic lng);
        ID_valid = 1'b1; ID_rs1 = rs1; ID_use_rs1 = u1; ID_rs2 = rs2; ID_use_rs2 = u2;
        ID_rd = rd; ID_RegWrite = rw; ID_long = lng;
    endtask

    // Called at posedge+1 with inputs already applied: queue expectations,
    // compare combinational outputs before the edge, registered ones after it.
    task automatic cyc(input string tag, input logic s, input logic i,
                       input logic [31:0] busy, input logic [2:0] pend);
        exp_t e;
        exp_t got;
        e.tag = tag; e.stall = s; e.issue = i; e.busy = busy; e.pend = pend;
        sb_q.push_back(e);
        #3;
        got = sb_q[0];
        check_eq({got.tag, ".stall"}, {31'd0, stall}, {31'd0, got.stall});
        check_eq({got.tag, ".issue"}, {31'd0, issue}, {31'd0, got.issue});
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq({got.tag, ".busy"}, busy_vec, got.busy);
        check_eq({got.tag, ".pend"}, {29'd0, pend_cnt}, {29'd0, got.pend});
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        // Reset state
        cyc("rst", 1'b0, 1'b0, 32'h0, 3'd0);
        check_eq("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check_eq("rst.err", {31'd0, err_spurious}, 32'd0);
        rstn = 1'b1;

        // T1: long write to x5
        idle(); id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cyc("t1.issue", 1'b0, 1'b1, 32'h20, 3'd1);

        // T2: RAW on pending x5, then same-cycle completion bypass
        idle(); id_op(5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        cyc("t2.raw0", 1'b1, 1'b0, 32'h20, 3'd1);
        cyc("t2.raw1", 1'b1, 1'b0, 32'h20, 3'd1);
        cmp_valid = 1'b1; cmp_rd = 5'd5;
        cyc("t2.bypass", 1'b0, 1'b0, 32'h0, 3'd0);

        // T3: load-use
        idle(); id_op(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        EX_MemRead = 1'b1; EX_rd = 5'd7;
        cyc("t3.lu", 1'b1, 1'b0, 32'h0, 3'd0);
        EX_MemRead = 1'b0;
        cyc("t3.lu_gone", 1'b0, 1'b0, 32'h0, 3'd0);
        EX_MemRead = 1'b1; EX_rd = 5'd0; ID_rs2 = 5'd0;
        cyc("t3.x0", 1'b0, 1'b0, 32'h0, 3'd0);
        idle(); id_op(5'd7, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        EX_MemRead = 1'b1; EX_rd = 5'd7;
        cyc("t3.unused_rs1", 1'b0, 1'b0, 32'h0, 3'd0);

        // T4: fill capacity, full stall, completion frees a slot same cycle
        idle(); id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        cyc("t4.x1", 1'b0, 1'b1, 32'h02, 3'd1);
        ID_rd = 5'd2;
        cyc("t4.x2", 1'b0, 1'b1, 32'h06, 3'd2);
        ID_rd = 5'd3;
        cyc("t4.x3", 1'b0, 1'b1, 32'h0E, 3'd3);
        ID_rd = 5'd4;
        cyc("t4.x4", 1'b0, 1'b1, 32'h1E, 3'd4);
        ID_rd = 5'd6;
        cyc("t4.full", 1'b1, 1'b0, 32'h1E, 3'd4);
        cmp_valid = 1'b1; cmp_rd = 5'd2;
        cyc("t4.full_cmp", 1'b0, 1'b1, 32'h5A, 3'd4);
        idle(); id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        cyc("t4.waw", 1'b1, 1'b0, 32'h5A, 3'd4);
        idle(); id_op(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
        cyc("t4.x0_long", 1'b0, 1'b0, 32'h5A, 3'd4);
        idle(); cmp_valid = 1'b1; cmp_rd = 5'd1;
        cyc("t4.c1", 1'b0, 1'b0, 32'h58, 3'd3);
        cmp_rd = 5'd3;
        cyc("t4.c3", 1'b0, 1'b0, 32'h50, 3'd2);
        cmp_rd = 5'd4;
        cyc("t4.c4", 1'b0, 1'b0, 32'h40, 3'd1);
        cmp_rd = 5'd6;
        cyc("t4.c6", 1'b0, 1'b0, 32'h00, 3'd0);
        check_eq("t4.err", {31'd0, err_spurious}, 32'd0);

        // T5: set wins over clear on same register; spurious completion
        idle(); id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        cyc("t5.x9", 1'b0, 1'b1, 32'h200, 3'd1);
        cmp_valid = 1'b1; cmp_rd = 5'd9;
        cyc("t5.setclr", 1'b0, 1'b1, 32'h200, 3'd1);
        idle(); cmp_valid = 1'b1; cmp_rd = 5'd3;
        cyc("t5.spur", 1'b0, 1'b0, 32'h200, 3'd1);
        check_eq("t5.err_set", {31'd0, err_spurious}, 32'd1);
        idle();
        cyc("t5.idle", 1'b0, 1'b0, 32'h200, 3'd1);
        check_eq("t5.err_sticky", {31'd0, err_spurious}, 32'd1);

        // T6: flush suppresses stall and issue, entries kept
        idle(); id_op(5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1); flush = 1'b1;
        cyc("t6.flush", 1'b0, 1'b0, 32'h200, 3'd1);
        check_eq("t6.cnt", {16'd0, stall_cnt}, 32'd5);

        // Saturation of the stall counter
        idle(); id_op(5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        for (int n = 0; n < 65536 + 3; n++) begin
            @(posedge clk);
        end
        #1;
        cyc("t6.sat", 1'b1, 1'b0, 32'h200, 3'd1);
        check_eq("t6.stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

        // Reset mid-operation
        idle(); rstn = 1'b0;
        cyc("rst2", 1'b0, 1'b0, 32'h0, 3'd0);
        check_eq("rst2.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check_eq("rst2.err", {31'd0, err_spurious}, 32'd0);
        rstn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
